// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, branch kinds,
// FSM states and the sequential multiplier step count.
package exe_pkg;

    localparam int MUL_STEPS = 32;
    localparam int STEP_W    = $clog2(MUL_STEPS);

    typedef enum logic [3:0] {
        CMD_ADD = 4'd0,
        CMD_SUB = 4'd1,
        CMD_AND = 4'd2,
        CMD_OR  = 4'd3,
        CMD_NOR = 4'd4,
        CMD_XOR = 4'd5,
        CMD_SLL = 4'd6,
        CMD_SRL = 4'd7,
        CMD_SRA = 4'd8,
        CMD_SLT = 4'd9,
        CMD_MUL = 4'd10
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEQ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

endpackage

// File: rtl/exe_seq_mul.sv
// Radix-2 shift-add multiplier producing the low 32 bits of a*b.
// One partial product is folded in per clock; o_done is high during the
// cycle whose edge completes the last step, and o_product is already the
// final value then, so the caller can register it at that same edge.
module exe_seq_mul
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    output logic        o_done,
    output logic [31:0] o_product
);

    logic [31:0]       r_mcand;
    logic [31:0]       r_mplier;
    logic [31:0]       r_acc;
    logic [STEP_W-1:0] r_step;
    logic              r_busy;

    logic [31:0]       w_addend;
    logic [31:0]       w_acc_next;

    // Partial product: the (already shifted) multiplicand gated by the
    // current multiplier LSB.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_addend
            assign w_addend[gi] = r_mcand[gi] & r_mplier[0];
        end
    endgenerate

    assign w_acc_next = r_acc + w_addend;
    assign o_product  = w_acc_next;
    assign o_done     = r_busy && (r_step == STEP_W'(MUL_STEPS - 1));

    // Operand load on start, then one shift-add step per clock until done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_step   <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= i_op_a;
            r_mplier <= i_op_b;
            r_acc    <= '0;
            r_step   <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_step   <= r_step + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Pipeline execute stage: single-cycle ALU and branch resolution, plus a
// 32-cycle sequential multiply during which the stage stalls upstream.
module exe_stage
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        wb_en,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  br,
    input  logic [3:0]  exe_cmd,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [31:0] imm,
    input  logic [4:0]  dest,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] alu_result,
    output logic [31:0] st_data,
    output logic [4:0]  dest_out,
    output logic        wb_en_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        br_taken,
    output logic [31:0] br_addr
);

    // Branch condition on a pair of operands.
    function automatic logic br_eval(input logic [1:0] br_sel,
                                     input logic [31:0] op_a,
                                     input logic [31:0] op_b);
        logic taken;
        taken = 1'b0;
        case (br_sel)
            BR_BEQ:  taken = (op_a == op_b);
            BR_BNE:  taken = (op_a != op_b);
            BR_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    state_e      r_state;
    state_e      w_state_next;

    // Bundle captured when a multiply is accepted; upstream may change
    // freely while the multiplier runs.
    logic [31:0] r_lat_reg1;
    logic [31:0] r_lat_reg2;
    logic [31:0] r_lat_br_addr;
    logic [1:0]  r_lat_br;
    logic [4:0]  r_lat_dest;
    logic        r_lat_wb_en;
    logic        r_lat_mem_read;
    logic        r_lat_mem_write;

    logic        r_out_valid;
    logic [31:0] r_alu_result;
    logic [31:0] r_st_data;
    logic [4:0]  r_dest_out;
    logic        r_wb_en_out;
    logic        r_mem_read_out;
    logic        r_mem_write_out;
    logic        r_br_taken;
    logic [31:0] r_br_addr;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_mul_start;
    logic        w_mul_done;
    logic        w_mul_finish;
    logic [31:0] w_mul_product;
    logic [31:0] w_alu_result;
    logic [31:0] w_br_addr;

    assign in_ready     = (r_state == ST_IDLE);
    assign w_accept     = in_valid && in_ready;
    assign w_is_mul     = (exe_cmd == CMD_MUL);
    assign w_mul_start  = w_accept && w_is_mul;
    assign w_mul_finish = (r_state == ST_MUL_RUN) && w_mul_done;
    assign w_br_addr    = pc_in + (imm << 2);

    exe_seq_mul u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_op_a    (reg1),
        .i_op_b    (reg2),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // Single-cycle ALU; MUL and reserved codes give 0 here.
    always_comb begin
        w_alu_result = '0;
        case (exe_cmd)
            CMD_ADD: w_alu_result = reg1 + reg2;
            CMD_SUB: w_alu_result = reg1 - reg2;
            CMD_AND: w_alu_result = reg1 & reg2;
            CMD_OR:  w_alu_result = reg1 | reg2;
            CMD_NOR: w_alu_result = ~(reg1 | reg2);
            CMD_XOR: w_alu_result = reg1 ^ reg2;
            CMD_SLL: w_alu_result = reg1 << reg2[4:0];
            CMD_SRL: w_alu_result = reg1 >> reg2[4:0];
            CMD_SRA: w_alu_result = $unsigned($signed(reg1) >>> reg2[4:0]);
            CMD_SLT: w_alu_result = {31'd0, ($signed(reg1) < $signed(reg2))};
            default: w_alu_result = '0;
        endcase
    end

    // Next-state logic: leave IDLE only on an accepted multiply.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_mul_start)  w_state_next = ST_MUL_RUN;
            ST_MUL_RUN: if (w_mul_finish) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the bundle of an accepted multiply for use at completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_reg1      <= '0;
            r_lat_reg2      <= '0;
            r_lat_br_addr   <= '0;
            r_lat_br        <= '0;
            r_lat_dest      <= '0;
            r_lat_wb_en     <= 1'b0;
            r_lat_mem_read  <= 1'b0;
            r_lat_mem_write <= 1'b0;
        end else if (w_mul_start) begin
            r_lat_reg1      <= reg1;
            r_lat_reg2      <= reg2;
            r_lat_br_addr   <= w_br_addr;
            r_lat_br        <= br;
            r_lat_dest      <= dest;
            r_lat_wb_en     <= wb_en;
            r_lat_mem_read  <= mem_read;
            r_lat_mem_write <= mem_write;
        end
    end

    // Output register: valid/taken pulse for one cycle, data holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_alu_result    <= '0;
            r_st_data       <= '0;
            r_dest_out      <= '0;
            r_wb_en_out     <= 1'b0;
            r_mem_read_out  <= 1'b0;
            r_mem_write_out <= 1'b0;
            r_br_taken      <= 1'b0;
            r_br_addr       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_br_taken  <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_out_valid     <= 1'b1;
                r_alu_result    <= w_alu_result;
                r_st_data       <= reg2;
                r_dest_out      <= dest;
                r_wb_en_out     <= wb_en;
                r_mem_read_out  <= mem_read;
                r_mem_write_out <= mem_write;
                r_br_taken      <= br_eval(br, reg1, reg2);
                r_br_addr       <= w_br_addr;
            end else if (w_mul_finish) begin
                r_out_valid     <= 1'b1;
                r_alu_result    <= w_mul_product;
                r_st_data       <= r_lat_reg2;
                r_dest_out      <= r_lat_dest;
                r_wb_en_out     <= r_lat_wb_en;
                r_mem_read_out  <= r_lat_mem_read;
                r_mem_write_out <= r_lat_mem_write;
                r_br_taken      <= br_eval(r_lat_br, r_lat_reg1, r_lat_reg2);
                r_br_addr       <= r_lat_br_addr;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign alu_result    = r_alu_result;
    assign st_data       = r_st_data;
    assign dest_out      = r_dest_out;
    assign wb_en_out     = r_wb_en_out;
    assign mem_read_out  = r_mem_read_out;
    assign mem_write_out = r_mem_write_out;
    assign br_taken      = r_br_taken;
    assign br_addr       = r_br_addr;

endmodule

// File: tb/tb_exe_stage.sv
// Directed and random checks of exe_stage against an arithmetic reference.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        wb_en;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  br;
    logic [3:0]  exe_cmd;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] alu_result;
    logic [31:0] st_data;
    logic [4:0]  dest_out;
    logic        wb_en_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        br_taken;
    logic [31:0] br_addr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .wb_en         (wb_en),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .br            (br),
        .exe_cmd       (exe_cmd),
        .reg1          (reg1),
        .reg2          (reg2),
        .imm           (imm),
        .dest          (dest),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .alu_result    (alu_result),
        .st_data       (st_data),
        .dest_out      (dest_out),
        .wb_en_out     (wb_en_out),
        .mem_read_out  (mem_read_out),
        .mem_write_out (mem_write_out),
        .br_taken      (br_taken),
        .br_addr       (br_addr)
    );

    // Reference ALU from the command table, using plain arithmetic.
    function automatic logic [31:0] model_alu(input int cmd, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] wide;
        longint      prod;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        case (cmd)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return ~(a | b);
            5:  return a ^ b;
            6:  return a << (b % 32);
            7:  return a >> (b % 32);
            8: begin
                wide = {{32{a[31]}}, a} >> (b % 32);
                return wide[31:0];
            end
            9:  return (sa < sb) ? 32'd1 : 32'd0;
            10: begin
                prod = longint'(a) * longint'(b);
                return prod[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_taken(input int kind, input logic [31:0] a,
                                         input logic [31:0] b);
        if (kind == 1) return a == b;
        if (kind == 2) return a != b;
        if (kind == 3) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        in_valid  = 1'b0;
        pc_in     = '0;
        wb_en     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        br        = '0;
        exe_cmd   = '0;
        reg1      = '0;
        reg2      = '0;
        imm       = '0;
        dest      = '0;
    endtask

    // One complete transaction: present, wait for the result within a bound,
    // compare every output field, then confirm the valid/taken pulse drops.
    task automatic run_op(input string tag, input logic [3:0] cmd, input logic [1:0] brk,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] im,
                          input logic [4:0] d, input logic wb, input logic mr,
                          input logic mw);
        logic [31:0] exp_res;
        logic [31:0] exp_addr;
        logic        exp_taken;
        int          cycles;
        int          ready_hi;
        exp_res   = model_alu(int'(cmd), a, b);
        exp_taken = model_taken(int'(brk), a, b);
        exp_addr  = pc + im * 4;
        @(negedge clk);
        chk({tag, " ready_before"}, {31'd0, in_ready}, 32'd1);
        exe_cmd = cmd; br = brk; reg1 = a; reg2 = b; pc_in = pc; imm = im;
        dest = d; wb_en = wb; mem_read = mr; mem_write = mw; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reg1 = $urandom; reg2 = $urandom; exe_cmd = 4'($urandom); pc_in = $urandom;
        imm = $urandom; br = 2'($urandom); dest = 5'($urandom);
        cycles   = 0;
        ready_hi = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            if (in_ready !== 1'b0) ready_hi++;
            @(posedge clk);
            #1;
            cycles++;
        end
        chk({tag, " latency"}, cycles, (cmd == 4'd10) ? 32'd32 : 32'd0);
        chk({tag, " ready_while_busy"}, ready_hi, 32'd0);
        chk({tag, " alu_result"}, alu_result, exp_res);
        chk({tag, " st_data"}, st_data, b);
        chk({tag, " dest_out"}, {27'd0, dest_out}, {27'd0, d});
        chk({tag, " ctl"}, {29'd0, wb_en_out, mem_read_out, mem_write_out},
            {29'd0, wb, mr, mw});
        chk({tag, " br_taken"}, {31'd0, br_taken}, {31'd0, exp_taken});
        chk({tag, " br_addr"}, br_addr, exp_addr);
        @(posedge clk);
        #1;
        chk({tag, " valid_pulse"}, {30'd0, out_valid, br_taken}, 32'd0);
        chk({tag, " data_hold"}, alu_result, exp_res);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int ready_hi;
        int pulses;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset alu_result", alu_result, 32'd0);
        chk("reset br_addr", br_addr, 32'd0);
        rst = 1'b0;

        // Bubbles in IDLE.
        pulses = 0;
        ready_hi = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) pulses++;
            if (in_ready === 1'b1) ready_hi++;
        end
        chk("bubble out_valid", pulses, 32'd0);
        chk("bubble in_ready", ready_hi, 32'd5);

        // Directed cases.
        run_op("add_wrap", 4'd0, 2'd0, 32'd5, 32'hFFFF_FFFF, 32'h40, 32'd1, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("add_wrap ready_after", {31'd0, in_ready}, 32'd1);
        run_op("sra_neg", 4'd8, 2'd0, 32'h8000_0000, 32'd4, 32'h0, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        run_op("slt_signed", 4'd9, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        run_op("beq_taken", 4'd0, 2'd1, 32'd7, 32'd7, 32'h100, 32'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        run_op("bne_not", 4'd0, 2'd2, 32'd7, 32'd7, 32'h100, 32'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        run_op("reserved", 4'd13, 2'd0, 32'd9, 32'd9, 32'h0, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1);
        run_op("mul_branch", 4'd10, 2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h200, 32'hFFFF_FFFF,
               5'd31, 1'b1, 1'b1, 1'b0);

        // MUL with a following ADD held at the input the whole time.
        @(negedge clk);
        exe_cmd = 4'd10; br = 2'd0; reg1 = 32'h1_0001; reg2 = 32'h1_0001;
        pc_in = 32'h0; imm = 32'h0; dest = 5'd3; wb_en = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        exe_cmd = 4'd0; reg1 = 32'd5; reg2 = 32'hFFFF_FFFF; dest = 5'd9;
        cycles = 0;
        ready_hi = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            if (in_ready !== 1'b0) ready_hi++;
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("mul_hold latency", cycles, 32'd32);
        chk("mul_hold ready_low", ready_hi, 32'd0);
        chk("mul_hold product", alu_result, 32'h0002_0001);
        chk("mul_hold dest", {27'd0, dest_out}, 32'd3);
        chk("mul_hold ready_back", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("held_add valid", {31'd0, out_valid}, 32'd1);
        chk("held_add result", alu_result, 32'd4);
        chk("held_add dest", {27'd0, dest_out}, 32'd9);

        // Reset in the middle of a multiply.
        @(negedge clk);
        exe_cmd = 4'd10; br = 2'd3; reg1 = 32'd3; reg2 = 32'd4; dest = 5'd5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst data", alu_result | st_data | br_addr, 32'd0);
        chk("midrst ctl", {26'd0, dest_out, br_taken}, 32'd0);
        chk("midrst flags", {29'd0, wb_en_out, mem_read_out, mem_write_out}, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) pulses++;
        end
        chk("midrst no_late_valid", pulses, 32'd0);
        run_op("mul_after_rst", 4'd10, 2'd0, 32'd3, 32'd4, 32'h0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0);

        // Random traffic against the reference model.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [3:0]  rc;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rc = 4'($urandom_range(0, 15));
            run_op($sformatf("rnd%0d_cmd%0d", i, rc), rc, 2'($urandom_range(0, 3)), ra, rb,
                   $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
